sysprint_ctrl: RTL and testbench
================================

Name: sysprint_ctrl

Overview:
- Syscall print sequencer and data-memory port arbiter, placed between the pipeline MEM stage and the data memory.
- Idle: passes the MEM-stage access straight through to the data memory.
- On a print-string syscall: stalls the pipeline, takes the memory port, walks the NUL-terminated string word by word, and streams its bytes to a console sink over a valid/ready handshake.
- Replaces simulation-only printing with synthesizable sequencing.

Parameters:
- MAX_WORDS, 256, word-fetch limit per string; reaching it forces termination.
- CNT_W, 9, width of the word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- sys_req  in  1  syscall strobe from pipeline, one cycle
- sys_v  in  32  syscall code ($v0)
- sys_a  in  32  argument ($a0); byte address of string or value
- pipe_addr  in  32  MEM-stage byte address
- pipe_wdata  in  32  MEM-stage store data
- pipe_we  in  1  MEM-stage word write
- pipe_we8  in  1  MEM-stage byte write
- pipe_rdata  out  32  read data returned to MEM stage
- mem_addr  out  32  data-memory byte address
- mem_wdata  out  32  data-memory write data
- mem_we  out  1  data-memory word write
- mem_we8  out  1  data-memory byte write
- mem_rdata  in  32  data-memory read data (combinational read)
- stall  out  1  pipeline freeze
- con_valid  out  1  console byte valid
- con_data  out  8  console byte
- con_ready  in  1  console accepts byte
- sys_done  out  1  one-cycle pulse when the print completes
- ovf  out  1  sticky; set when MAX_WORDS terminates a string, cleared on the next accepted sys_req

Behaviour:
- Reset values:
  - state = IDLE
  - stall, con_valid, sys_done, ovf = 0
  - con_data, ptr, idx, cnt, wbuf = 0
- Reset is asynchronous and may assert mid-operation: the block aborts immediately, drops con_valid and releases stall.
- States: IDLE, FETCH, EMIT, NL, DONE.
- IDLE:
  - All mem_* outputs follow pipe_*; pipe_rdata = mem_rdata.
  - A sys_req with sys_v == 4 is accepted:
    - stall = 1 in the same cycle (combinational).
    - ptr = sys_a[31:2]; cnt = 0; ovf = 0.
    - Next state = FETCH.
  - sys_req with any other code: ignored, no stall, no sys_done.
- Memory port outside IDLE:
  - mem_addr = {ptr, 2'b00}.
  - mem_we = mem_we8 = 0; pipeline stores are blocked.
  - pipe_rdata is held at its last IDLE value.
- FETCH (one cycle):
  - wbuf = mem_rdata; cnt = cnt + 1; idx = 0.
  - If mem_rdata == 0, go to NL; otherwise go to EMIT.
- EMIT: byte order is little-endian, byte[idx] = wbuf[8*idx+7 : 8*idx].
  - Byte is zero: go to NL without emitting it.
  - Otherwise: con_valid = 1, con_data = byte.
  - On con_valid && con_ready:
    - idx < 3: idx = idx + 1.
    - idx == 3: ptr = ptr + 1 (30-bit wrap); go to FETCH, or to NL with ovf = 1 if cnt == MAX_WORDS.
- Console handshake:
  - con_data is stable while con_valid = 1 and ready is low.
  - Valid never drops without a handshake.
  - con_ready may be held low indefinitely.
- NL: present 0x0A; on handshake go to DONE.
- DONE (one cycle): sys_done = 1, stall = 0, next state = IDLE.
- sys_req arriving in any non-IDLE state is ignored.

Optional Feature:
- Macro: SYSPRINT_HEX_EN
- Defined: sys_v == 34 is also accepted.
  - Emits 8 ASCII hex digits of sys_a, MSB nibble first, lowercase a–f.
  - Then NL and DONE, identical to the string path.
  - No memory access; the memory port stays in pass-through.
  - Adds state HEX with a 3-bit nibble index.
- Not defined: code 34 is ignored like any other unsupported code.

Decomposition:
- Shared package sysprint_pkg:
  - state enum
  - constants SYS_PRINT_STR = 4, SYS_PRINT_HEX = 34, ASCII_NL = 8'h0A
- Sub-module sysprint_con_reg:
  - Holds con_valid/con_data.
  - Enforces valid/data hold until ready.
  - Reports the handshake to the FSM.

Test Plan:
- Pass-through: IDLE, pipe_we = 1, pipe_addr = 0x00100010, pipe_wdata = 0xDEADBEEF → mem_we = 1 with the same addr/data the same cycle; stall = 0.
- String print: RAM @0x00100000 = 0x00216948, @0x00100004 = 0; sys_req, sys_v = 4, sys_a = 0x00100000, con_ready = 1:
  - con bytes 0x48, 0x69, 0x21, 0x0A.
  - sys_done pulses once; stall high from the req cycle through DONE.
  - No mem writes occur.
- Backpressure: same string, con_ready toggling 1-in-3 → identical byte sequence, con_data stable while stalled, no duplicates.
- Overflow: MAX_WORDS = 2, RAM filled with 0x41414141 → exactly eight 0x41 bytes, then 0x0A; ovf = 1; next accepted sys_req clears ovf.
- Reset mid-EMIT: assert rst_n = 0 during the second byte → con_valid, stall = 0 immediately; after release, IDLE pass-through works.
- Ignored codes: sys_req with sys_v = 10 → no stall, no con_valid, no sys_done. With SYSPRINT_HEX_EN, sys_v = 34, sys_a = 0x00C0FFEE → "00c0ffee", 0x0A, sys_done.

Source files
------------

// File: rtl/sysprint_pkg.sv
// Shared types and constants for the syscall print sequencer.
// The hex-print path is compiled in with SYSPRINT_HEX_EN.
package sysprint_pkg;

  localparam logic [31:0] SYS_PRINT_STR = 32'd4;
  localparam logic [31:0] SYS_PRINT_HEX = 32'd34;
  localparam logic [7:0]  ASCII_NL      = 8'h0A;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EMIT  = 3'd2,
    NL    = 3'd3,
    DONE  = 3'd4,
    HEX   = 3'd5
  } state_t;

  // Lowercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    hex_char = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

endpackage

// File: rtl/sysprint_con_reg.sv
// Console output register: holds valid/data until the sink accepts,
// and only takes a new byte when empty or when the current one leaves.
module sysprint_con_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       con_ready,
  output logic       con_valid,
  output logic [7:0] con_data,
  output logic       hs
);

  assign hs = con_valid && con_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      con_valid <= 1'b0;
      con_data  <= 8'h00;
    end else if (!con_valid || con_ready) begin
      con_valid <= load;
      if (load) con_data <= load_data;
    end
  end

endmodule

// File: rtl/sysprint_ctrl.sv
// Syscall print sequencer and data-memory port arbiter.
// Define SYSPRINT_HEX_EN to also accept code 34 (print sys_a as 8 hex digits).
module sysprint_ctrl
  import sysprint_pkg::*;
#(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sys_req,
  input  logic [31:0] sys_v,
  input  logic [31:0] sys_a,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic        pipe_we,
  input  logic        pipe_we8,
  output logic [31:0] pipe_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_we8,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        sys_done,
  output logic        ovf
);

  state_t           state_reg, state_next;
  logic [29:0]      ptr_reg, ptr_next;
  logic [1:0]       idx_reg, idx_next, idx_inc;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [31:0]      wbuf_reg, wbuf_next;
  logic [31:0]      rdata_hold_reg;
  logic             ovf_reg, ovf_next;
  logic             load, hs, port_pass;
  logic [7:0]       load_data, next_byte;
  logic             unused_sys_a;
`ifdef SYSPRINT_HEX_EN
  logic [2:0]       nib_reg, nib_next, nib_inc;
`endif

  assign unused_sys_a = ^sys_a[1:0];

  sysprint_con_reg u_con (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .con_ready (con_ready),
    .con_valid (con_valid),
    .con_data  (con_data),
    .hs        (hs)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      ptr_reg        <= '0;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      wbuf_reg       <= '0;
      ovf_reg        <= 1'b0;
      rdata_hold_reg <= '0;
`ifdef SYSPRINT_HEX_EN
      nib_reg        <= '0;
`endif
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
      cnt_reg   <= cnt_next;
      wbuf_reg  <= wbuf_next;
      ovf_reg   <= ovf_next;
      if (state_reg == IDLE) rdata_hold_reg <= mem_rdata;
`ifdef SYSPRINT_HEX_EN
      nib_reg   <= nib_next;
`endif
    end
  end

  // The console register always holds the byte being offered, so each
  // handshake loads the following byte (look-ahead on the zero terminator).
  assign idx_inc   = idx_reg + 2'd1;
  assign next_byte = wbuf_reg[{idx_inc, 3'b000} +: 8];
`ifdef SYSPRINT_HEX_EN
  assign nib_inc   = nib_reg + 3'd1;
`endif

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;
    cnt_next   = cnt_reg;
    wbuf_next  = wbuf_reg;
    ovf_next   = ovf_reg;
    load       = 1'b0;
    load_data  = ASCII_NL;
    stall      = 1'b1;
    sys_done   = 1'b0;
`ifdef SYSPRINT_HEX_EN
    nib_next   = nib_reg;
`endif
    case (state_reg)
      IDLE: begin
        stall = 1'b0;
        if (sys_req && sys_v == SYS_PRINT_STR) begin
          stall      = 1'b1;
          ptr_next   = sys_a[31:2];
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = FETCH;
        end
`ifdef SYSPRINT_HEX_EN
        else if (sys_req && sys_v == SYS_PRINT_HEX) begin
          stall      = 1'b1;
          wbuf_next  = sys_a;
          nib_next   = '0;
          ovf_next   = 1'b0;
          load       = 1'b1;
          load_data  = hex_char(sys_a[31:28]);
          state_next = HEX;
        end
`endif
      end
      FETCH: begin
        wbuf_next = mem_rdata;
        cnt_next  = cnt_reg + CNT_W'(1);
        idx_next  = '0;
        load      = 1'b1;
        if (mem_rdata[7:0] == 8'h00) begin
          state_next = NL;
        end else begin
          load_data  = mem_rdata[7:0];
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (hs) begin
          if (idx_reg != 2'd3) begin
            load = 1'b1;
            if (next_byte == 8'h00) begin
              state_next = NL;
            end else begin
              load_data = next_byte;
              idx_next  = idx_inc;
            end
          end else begin
            ptr_next = ptr_reg + 30'd1;
            if (cnt_reg == CNT_W'(MAX_WORDS)) begin
              ovf_next   = 1'b1;
              load       = 1'b1;
              state_next = NL;
            end else begin
              state_next = FETCH;
            end
          end
        end
      end
      NL: begin
        if (hs) state_next = DONE;
      end
      DONE: begin
        stall      = 1'b0;
        sys_done   = 1'b1;
        state_next = IDLE;
      end
`ifdef SYSPRINT_HEX_EN
      HEX: begin
        if (hs) begin
          load = 1'b1;
          if (nib_reg != 3'd7) begin
            nib_next  = nib_inc;
            load_data = hex_char(wbuf_reg[{3'd7 - nib_inc, 2'b00} +: 4]);
          end else begin
            state_next = NL;
          end
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

`ifdef SYSPRINT_HEX_EN
  assign port_pass = (state_reg == IDLE) || (state_reg == HEX);
`else
  assign port_pass = (state_reg == IDLE);
`endif

  always_comb begin
    mem_wdata = pipe_wdata;
    if (port_pass) begin
      mem_addr   = pipe_addr;
      mem_we     = pipe_we;
      mem_we8    = pipe_we8;
      pipe_rdata = mem_rdata;
    end else begin
      mem_addr   = {ptr_reg, 2'b00};
      mem_we     = 1'b0;
      mem_we8    = 1'b0;
      pipe_rdata = rdata_hold_reg;
    end
  end

  assign ovf = ovf_reg;

endmodule

// File: tb/tb_sysprint_ctrl.sv
// Self-checking bench for sysprint_ctrl: pass-through vector table plus
// scoreboarded print sequences (string, backpressure, overflow, reset, hex).
module tb_sysprint_ctrl;

  localparam int MAXW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sys_req = 1'b0;
  logic [31:0] sys_v = '0, sys_a = '0;
  logic [31:0] pipe_addr = '0, pipe_wdata = '0;
  logic        pipe_we = 1'b0, pipe_we8 = 1'b0;
  logic [31:0] pipe_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_we8, stall, con_valid, con_ready, sys_done, ovf;
  logic [7:0]  con_data;

  logic [31:0] ram [0:1023];
  assign mem_rdata = ram[mem_addr[11:2]];

  sysprint_ctrl #(.MAX_WORDS(MAXW), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .sys_req(sys_req), .sys_v(sys_v), .sys_a(sys_a),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_we(pipe_we),
    .pipe_we8(pipe_we8), .pipe_rdata(pipe_rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_we8(mem_we8),
    .mem_rdata(mem_rdata), .stall(stall), .con_valid(con_valid),
    .con_data(con_data), .con_ready(con_ready), .sys_done(sys_done), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Console ready pattern: 0 = always ready, 1 = ready one cycle in three.
  int ready_mode = 0;
  int rc = 0;
  initial begin
    con_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rc++;
      con_ready = (ready_mode == 0) ? 1'b1 : (rc % 3 == 0);
    end
  end

  // Scoreboard monitor: expected console bytes are queued by the stimulus.
  logic [7:0] exp_q[$];
  int         popped = 0;
  int         we_bad = 0;
  logic       prev_stuck = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stuck = 1'b0;
    end else begin
      if (prev_stuck) begin
        chk("con_valid_hold", {31'd0, con_valid}, 32'd1);
        chk("con_data_hold", {24'd0, con_data}, {24'd0, prev_data});
      end
      if (con_valid && con_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL con_extra actual=%h required=none", con_data);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("con_byte", {24'd0, con_data}, {24'd0, e});
          $display("console byte %h (expected %h)", con_data, e);
        end
        popped++;
      end
      if (stall && !sys_req && mem_we) we_bad++;
      prev_stuck = con_valid && !con_ready;
      prev_data  = con_data;
    end
  end

  function automatic logic [7:0] hexc(input logic [3:0] n);
    string s;
    s = "0123456789abcdef";
    return s[n];
  endfunction

  // Expected console stream for a request; returns the expected ovf flag.
  task automatic model(input logic [31:0] v, input logic [31:0] a, output logic eovf);
    eovf = 1'b0;
    if (v == 32'd34) begin
      for (int i = 7; i >= 0; i--) exp_q.push_back(hexc(a[4*i +: 4]));
    end else begin
      logic stop;
      stop = 1'b0;
      for (int k = 0; k < MAXW && !stop; k++) begin
        logic [31:0] w;
        w = ram[a[11:2] + 10'(k)];
        for (int b = 0; b < 4 && !stop; b++) begin
          if (w[8*b +: 8] == 8'h00) stop = 1'b1;
          else exp_q.push_back(w[8*b +: 8]);
        end
        if (!stop && k == MAXW - 1) eovf = 1'b1;
      end
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic run_print(input string nm, input logic [31:0] v, input logic [31:0] a);
    logic eovf;
    int   cyc, gap;
    model(v, a, eovf);
    we_bad = 0;
    @(posedge clk); #1;
    sys_req = 1'b1; sys_v = v; sys_a = a;
    pipe_addr = 32'h0010_0010; pipe_we = 1'b0;
    @(negedge clk);
    chk({nm, "_stall_req"}, {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    sys_req = 1'b0;
    pipe_we = (v == 32'd4);
    pipe_wdata = 32'h1234_5678;
    @(negedge clk);
    chk({nm, "_ovf_clear"}, {31'd0, ovf}, 32'd0);
    if (v == 32'd4) chk({nm, "_rdata_hold"}, pipe_rdata, 32'hCAFE_F00D);
    cyc = 0; gap = 0;
    while (cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (sys_done) break;
      if (!stall) gap++;
    end
    chk({nm, "_done"}, {31'd0, sys_done}, 32'd1);
    chk({nm, "_stall_at_done"}, {31'd0, stall}, 32'd0);
    chk({nm, "_stall_gaps"}, gap, 0);
    @(posedge clk); #1;
    pipe_we = 1'b0;
    @(negedge clk);
    chk({nm, "_done_once"}, {31'd0, sys_done}, 32'd0);
    chk({nm, "_queue_empty"}, exp_q.size(), 0);
    chk({nm, "_ovf"}, {31'd0, ovf}, {31'd0, eovf});
    chk({nm, "_no_mem_we"}, we_bad, 0);
    $display("print %s code=%0d addr=%h done after %0d cycles ovf=%b", nm, v, a, cyc, ovf);
  endtask

  typedef struct packed {
    logic        req;
    logic [31:0] v;
    logic        we;
    logic        we8;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    ram[0]  = 32'h0021_6948;
    ram[4]  = 32'hCAFE_F00D;
    ram[8]  = 32'h1122_3344;
    for (int i = 64; i < 68; i++) ram[i] = 32'h4141_4141;

    vecs.push_back('{1'b0, 32'd0,  1'b1, 1'b0, 32'h0010_0010, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b1, 32'h0010_0021, 32'h0000_00A5, 1'b0});
    vecs.push_back('{1'b0, 32'd0,  1'b0, 1'b0, 32'h0010_0000, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'd10, 1'b0, 1'b0, 32'h0010_0004, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b1, 32'd1,  1'b1, 1'b0, 32'h0010_0020, 32'h5555_AAAA, 1'b0});
`ifndef SYSPRINT_HEX_EN
    vecs.push_back('{1'b1, 32'd34, 1'b0, 1'b0, 32'h0010_0000, 32'h0000_0000, 1'b0});
`endif

    // Reset state
    #2;
    @(negedge clk);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_con_valid", {31'd0, con_valid}, 32'd0);
    chk("rst_con_data", {24'd0, con_data}, 32'd0);
    chk("rst_sys_done", {31'd0, sys_done}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Pass-through and ignored codes
    foreach (vecs[i]) begin
      @(posedge clk); #1;
      sys_req = vecs[i].req; sys_v = vecs[i].v; sys_a = 32'h0010_0000;
      pipe_we = vecs[i].we; pipe_we8 = vecs[i].we8;
      pipe_addr = vecs[i].addr; pipe_wdata = vecs[i].wdata;
      @(negedge clk);
      chk("pt_addr", mem_addr, vecs[i].addr);
      chk("pt_wdata", mem_wdata, vecs[i].wdata);
      chk("pt_we", {31'd0, mem_we}, {31'd0, vecs[i].we});
      chk("pt_we8", {31'd0, mem_we8}, {31'd0, vecs[i].we8});
      chk("pt_rdata", pipe_rdata, ram[vecs[i].addr[11:2]]);
      chk("pt_stall", {31'd0, stall}, {31'd0, vecs[i].exp_stall});
      @(posedge clk); #1;
      sys_req = 1'b0; pipe_we = 1'b0; pipe_we8 = 1'b0;
      @(negedge clk);
      chk("pt_stall_next", {31'd0, stall}, 32'd0);
      chk("pt_con_valid", {31'd0, con_valid}, 32'd0);
      chk("pt_sys_done", {31'd0, sys_done}, 32'd0);
      $display("vector %0d req=%b v=%0d addr=%h mem_we=%b stall=%b", i, vecs[i].req,
               vecs[i].v, mem_addr, mem_we, stall);
    end

    ready_mode = 0;
    run_print("str", 32'd4, 32'h0010_0000);
    ready_mode = 1;
    run_print("bp", 32'd4, 32'h0010_0000);
    ready_mode = 0;
    run_print("ovf", 32'd4, 32'h0010_0100);
    run_print("ovf_clr", 32'd4, 32'h0010_0000);

    // Reset asserted while the second byte is being offered
    begin
      logic eovf;
      int   p0, cyc;
      ready_mode = 1;
      model(32'd4, 32'h0010_0000, eovf);
      p0 = popped;
      @(posedge clk); #1;
      sys_req = 1'b1; sys_v = 32'd4; sys_a = 32'h0010_0000;
      @(posedge clk); #1;
      sys_req = 1'b0;
      cyc = 0;
      while (!(popped >= p0 + 1 && con_valid) && cyc < 100) begin
        @(negedge clk); #1;
        cyc++;
      end
      chk("rst_mid_reached", {31'd0, (cyc < 100)}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_con_valid", {31'd0, con_valid}, 32'd0);
      chk("rst_mid_stall", {31'd0, stall}, 32'd0);
      exp_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      ready_mode = 0;
      pipe_we = 1'b1; pipe_addr = 32'h0010_0030; pipe_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      chk("rst_mid_pt_we", {31'd0, mem_we}, 32'd1);
      chk("rst_mid_pt_addr", mem_addr, 32'h0010_0030);
      chk("rst_mid_pt_stall", {31'd0, stall}, 32'd0);
      $display("reset mid-emit after %0d bytes, pass-through addr=%h", popped - p0, mem_addr);
      @(posedge clk); #1;
      pipe_we = 1'b0;
    end

`ifdef SYSPRINT_HEX_EN
    run_print("hex", 32'd34, 32'h00C0_FFEE);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
